// File: rtl/booth_mult_seq_if.sv
// Handshake bundle for booth_mult_seq: operand/mode input channel, product output channel and busy.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, multiplicand, multiplier, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation, valid/ready on both sides.
// Optional BOOTH_EARLY_TERM_EN: a zero operand skips CALC and goes straight to DONE with product 0.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  booth_mult_seq_if.slave bus
);
  localparam int W  = WIDTH + 1;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [W:0]         a;
  logic [W-1:0]       q;
  logic               q1;
  logic [W-1:0]       m;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] product_r;

  logic [W-1:0]       mc_ext;
  logic [W-1:0]       mp_ext;
  logic [W:0]         m_ext;
  logic [W:0]         a_sum;
  logic [W:0]         a_next;
  logic [W-1:0]       q_next;

  // Operands widen by one bit so the unsigned range also fits a signed W-bit Booth recoding.
  assign mc_ext = {bus.is_signed & bus.multiplicand[WIDTH-1], bus.multiplicand};
  assign mp_ext = {bus.is_signed & bus.multiplier[WIDTH-1], bus.multiplier};
  assign m_ext  = {m[W-1], m};

  always_comb begin
    a_sum = a;
    case ({q[0], q1})
      2'b01:   a_sum = a + m_ext;
      2'b10:   a_sum = a - m_ext;
      default: a_sum = a;
    endcase
  end

  assign a_next = {a_sum[W], a_sum[W:1]};
  assign q_next = {a_sum[0], q[W-1:1]};

`ifdef BOOTH_EARLY_TERM_EN
  logic zero_op;
  assign zero_op = (bus.multiplicand == '0) || (bus.multiplier == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      q1        <= 1'b0;
      m         <= '0;
      count     <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a     <= '0;
            q     <= mp_ext;
            q1    <= 1'b0;
            m     <= mc_ext;
            count <= CW'(W);
`ifdef BOOTH_EARLY_TERM_EN
            if (zero_op) begin
              state     <= DONE;
              product_r <= '0;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          a     <= a_next;
          q     <= q_next;
          q1    <= q[0];
          count <= count - CW'(1);
          // Last step: capture the product from the shifted value that is being written this cycle.
          if (count == CW'(1)) begin
            state     <= DONE;
            product_r <= {a_next[WIDTH-2:0], q_next};
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = product_r;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomized checks of booth_mult_seq at WIDTH=8, 32 and 5.
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef BOOTH_EARLY_TERM_EN
  localparam int zero_lat = 1;
`else
  localparam int zero_lat = 10;
`endif

  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(8))  bus8 ();
  booth_mult_seq_if #(.WIDTH(32)) bus32 ();
  booth_mult_seq_if #(.WIDTH(5))  bus5 ();

  booth_mult_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  booth_mult_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  booth_mult_seq #(.WIDTH(5))  u5  (.clk(clk), .rst(rst), .bus(bus5.slave));

  // Independent reference: extend to 64 bits, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input int w);
    logic [63:0] ex, ey, p, mask;
    mask = (w >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ex = {32'd0, x} & mask;
    ey = {32'd0, y} & mask;
    if (s && ex[w-1]) ex = ex | ~mask;
    if (s && ey[w-1]) ey = ey | ~mask;
    p = ex * ey;
    if (w < 32) p = p & ((64'd1 << (2*w)) - 64'd1);
    return p;
  endfunction

  task automatic start8(input logic [7:0] mc, input logic [7:0] mp, input logic s);
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.multiplicand = mc; bus8.multiplier = mp; bus8.is_signed = s;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.multiplicand = ~mc; bus8.multiplier = mp ^ 8'h5A; bus8.is_signed = ~s;
  endtask

  task automatic wait8(output int cyc);
    cyc = 1;
    while (!bus8.out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic release8();
    @(negedge clk); bus8.out_ready = 1'b1;
    @(posedge clk); #1; bus8.out_ready = 1'b0;
  endtask

  task automatic run8(input logic [7:0] mc, input logic [7:0] mp, input logic s,
                      output logic [15:0] prod, output int cyc);
    start8(mc, mp, s);
    wait8(cyc);
    prod = bus8.product;
    release8();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus8.in_ready); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus8.out_valid); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", bus8.busy); end
    checks++; if (bus8.product !== 16'h0000) begin errors++; $display("[TB] FAIL reset_product got=%h want=0000", bus8.product); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_signed();
    logic [15:0] p; int cyc;
    start8(8'hFD, 8'h05, 1'b1);
    checks++; if (bus8.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_calc got=%b want=1", bus8.busy); end
    checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL in_ready_calc got=%b want=0", bus8.in_ready); end
    wait8(cyc);
    p = bus8.product;
    release8();
    checks++; if (p !== 16'hFFF1) begin errors++; $display("[TB] FAIL signed_m3x5 got=%h want=FFF1", p); end
    checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL latency got=%0d want=10", cyc); end
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_after_handshake got=%b want=1", bus8.in_ready); end
  endtask

  task automatic test_unsigned();
    logic [15:0] p; int cyc;
    run8(8'hFF, 8'hFF, 1'b0, p, cyc);
    checks++; if (p !== 16'hFE01) begin errors++; $display("[TB] FAIL unsigned_255x255 got=%h want=FE01", p); end
    run8(8'hFF, 8'hFF, 1'b1, p, cyc);
    checks++; if (p !== 16'h0001) begin errors++; $display("[TB] FAIL signed_m1xm1 got=%h want=0001", p); end
  endtask

  task automatic test_corners();
    logic [15:0] p; int cyc;
    run8(8'h80, 8'h80, 1'b1, p, cyc);
    checks++; if (p !== 16'h4000) begin errors++; $display("[TB] FAIL signed_m128xm128 got=%h want=4000", p); end
    run8(8'h7F, 8'h80, 1'b1, p, cyc);
    checks++; if (p !== 16'hC080) begin errors++; $display("[TB] FAIL signed_127xm128 got=%h want=C080", p); end
    run8(8'h80, 8'hFF, 1'b0, p, cyc);
    checks++; if (p !== 16'h7F80) begin errors++; $display("[TB] FAIL unsigned_128x255 got=%h want=7F80", p); end
  endtask

  task automatic test_backpressure();
    int cyc;
    start8(8'h0B, 8'h0D, 1'b0);
    wait8(cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.multiplicand = 8'h11; bus8.multiplier = 8'h22;
      @(posedge clk); #1;
      checks++; if (bus8.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid[%0d] got=%b want=1", i, bus8.out_valid); end
      checks++; if (bus8.product !== 16'h008F) begin errors++; $display("[TB] FAIL bp_product[%0d] got=%h want=008F", i, bus8.product); end
      checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d] got=%b want=0", i, bus8.in_ready); end
    end
    @(negedge clk); bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    @(posedge clk); #1; bus8.out_ready = 1'b0;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready got=%b want=1", bus8.in_ready); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_out_valid got=%b want=0", bus8.out_valid); end
  endtask

  task automatic test_reset_midop();
    logic [15:0] p; int cyc;
    start8(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got=%b want=1", bus8.in_ready); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got=%b want=0", bus8.out_valid); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b want=0", bus8.busy); end
    @(negedge clk); rst = 1'b0;
    run8(8'h07, 8'h06, 1'b0, p, cyc);
    checks++; if (p !== 16'h002A) begin errors++; $display("[TB] FAIL after_reset_7x6 got=%h want=002A", p); end
  endtask

  task automatic test_zero();
    logic [15:0] p; int cyc;
    run8(8'h00, 8'h9C, 1'b1, p, cyc);
    checks++; if (p !== 16'h0000) begin errors++; $display("[TB] FAIL zero_0x9C got=%h want=0000", p); end
    checks++; if (cyc !== zero_lat) begin errors++; $display("[TB] FAIL zero_latency got=%0d want=%0d", cyc, zero_lat); end
    run8(8'h9C, 8'h00, 1'b0, p, cyc);
    checks++; if (p !== 16'h0000) begin errors++; $display("[TB] FAIL zero_9Cx0 got=%h want=0000", p); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y; logic s; logic [63:0] want; int cyc;
    for (int i = 0; i < 20; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
      if (i == 0) begin x = 32'h8000_0000; y = 32'h8000_0000; s = 1'b1; end
      if (i == 1) begin x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; s = 1'b0; end
      want = ref_mul(x, y, s, 32);
      @(negedge clk);
      bus32.in_valid = 1'b1; bus32.multiplicand = x; bus32.multiplier = y; bus32.is_signed = s;
      @(posedge clk); #1; bus32.in_valid = 1'b0;
      cyc = 1;
      while (!bus32.out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
      checks++; if (bus32.product !== want) begin errors++; $display("[TB] FAIL w32_op%0d s=%b %h*%h got=%h want=%h", i, s, x, y, bus32.product, want); end
      @(negedge clk); bus32.out_ready = 1'b1;
      @(posedge clk); #1; bus32.out_ready = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      x = {27'd0, 5'($urandom)}; y = {27'd0, 5'($urandom)}; s = 1'($urandom_range(0, 1));
      if (i == 0) begin x = 32'h10; y = 32'h10; s = 1'b1; end
      if (i == 1) begin x = 32'h1F; y = 32'h1F; s = 1'b0; end
      want = ref_mul(x, y, s, 5);
      @(negedge clk);
      bus5.in_valid = 1'b1; bus5.multiplicand = x[4:0]; bus5.multiplier = y[4:0]; bus5.is_signed = s;
      @(posedge clk); #1; bus5.in_valid = 1'b0;
      cyc = 1;
      while (!bus5.out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
      checks++; if ({54'd0, bus5.product} !== want) begin errors++; $display("[TB] FAIL w5_op%0d s=%b %h*%h got=%h want=%h", i, s, x[4:0], y[4:0], bus5.product, want[9:0]); end
      @(negedge clk); bus5.out_ready = 1'b1;
      @(posedge clk); #1; bus5.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus8.in_valid = 1'b0;  bus8.multiplicand = '0;  bus8.multiplier = '0;  bus8.is_signed = 1'b0;  bus8.out_ready = 1'b0;
    bus32.in_valid = 1'b0; bus32.multiplicand = '0; bus32.multiplier = '0; bus32.is_signed = 1'b0; bus32.out_ready = 1'b0;
    bus5.in_valid = 1'b0;  bus5.multiplicand = '0;  bus5.multiplier = '0;  bus5.is_signed = 1'b0;  bus5.out_ready = 1'b0;
    test_reset();
    test_signed();
    test_unsigned();
    test_corners();
    test_backpressure();
    test_reset_midop();
    test_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
